uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_pkg.sv | 6 +
 rtl/uart_tx_sched_rr_arb2.sv | 11 +
 rtl/uart_tx_sched.sv | 111 +++++++++++
 tb/tb_uart_tx_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: state encoding and requester indices shared by the scheduler and its arbiter
package uart_tx_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_HI, WAIT_LO, NEXT} state_t;
  localparam int REQ_ALU = 0;
  localparam int REQ_RF  = 1;
endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// rr_arb2: two-way round-robin grant; last names the requester served most recently
module rr_arb2
  import uart_tx_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt[REQ_ALU] = req[REQ_ALU] & (!req[REQ_RF] | last);
  assign gnt[REQ_RF]  = req[REQ_RF] & (!req[REQ_ALU] | !last);
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: feeds ALU words (low byte first) and RF bytes to a UART transmitter.
// Optional watchdog on the busy handshake: define UART_TX_SCHED_WATCHDOG_EN.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WD_LIMIT   = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    alu_req,
  input  logic [2*DATA_WIDTH-1:0] alu_data,
  output logic                    alu_ack,
  input  logic                    rf_req,
  input  logic [DATA_WIDTH-1:0]   rf_data,
  output logic                    rf_ack,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_data_valid,
  input  logic                    tx_busy,
  output logic                    sched_busy,
  output logic                    wd_err
);
  localparam int CW = WD_LIMIT > 1 ? $clog2(WD_LIMIT) : 1;
  state_t state, state_n;
  logic [2*DATA_WIDTH-1:0] hold, hold_n;
  logic [DATA_WIDTH-1:0] pdata_n;
  logic [1:0] gnt;
  logic hi, hi_n, sel, sel_n, last, last_n;
  logic alu_ack_n, rf_ack_n, valid_n, wd_n;
  logic [CW-1:0] cnt, cnt_n;
  rr_arb2 u_arb (.req({rf_req, alu_req}), .last(last), .gnt(gnt));
  assign sched_busy = state != IDLE;
  // hi: high byte of an ALU word still owed; sel: the byte being sent is the high one
  always_comb begin
    state_n   = state;
    hold_n    = hold;
    hi_n      = hi;
    sel_n     = sel;
    last_n    = last;
    alu_ack_n = 1'b0;
    rf_ack_n  = 1'b0;
    valid_n   = 1'b0;
    wd_n      = 1'b0;
    cnt_n     = '0;
    pdata_n   = tx_p_data;
    case (state)
      IDLE: if (|gnt) begin
        state_n   = LOAD;
        last_n    = gnt[REQ_RF];
        alu_ack_n = gnt[REQ_ALU];
        rf_ack_n  = gnt[REQ_RF];
        hold_n    = gnt[REQ_ALU] ? alu_data : {{DATA_WIDTH{1'b0}}, rf_data};
        hi_n      = gnt[REQ_ALU];
        sel_n     = 1'b0;
      end
      LOAD: if (!tx_busy) begin
        valid_n = 1'b1;
        pdata_n = sel ? hold[2*DATA_WIDTH-1:DATA_WIDTH] : hold[DATA_WIDTH-1:0];
        state_n = WAIT_HI;
      end
`ifdef UART_TX_SCHED_WATCHDOG_EN
      WAIT_HI: if (tx_busy) state_n = WAIT_LO;
        else if (cnt == CW'(WD_LIMIT - 1)) begin
          wd_n    = 1'b1;
          hi_n    = 1'b0;
          state_n = IDLE;
        end else cnt_n = cnt + 1'b1;
`else
      WAIT_HI: if (tx_busy) state_n = WAIT_LO;
`endif
      WAIT_LO: if (!tx_busy) state_n = hi ? NEXT : IDLE;
      NEXT: begin
        sel_n   = 1'b1;
        hi_n    = 1'b0;
        state_n = LOAD;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state         <= IDLE;
      hold          <= '0;
      hi            <= 1'b0;
      sel           <= 1'b0;
      last          <= 1'b1;
      alu_ack       <= 1'b0;
      rf_ack        <= 1'b0;
      tx_data_valid <= 1'b0;
      tx_p_data     <= '0;
      cnt           <= '0;
    end else begin
      state         <= state_n;
      hold          <= hold_n;
      hi            <= hi_n;
      sel           <= sel_n;
      last          <= last_n;
      alu_ack       <= alu_ack_n;
      rf_ack        <= rf_ack_n;
      tx_data_valid <= valid_n;
      tx_p_data     <= pdata_n;
      cnt           <= cnt_n;
    end
`ifdef UART_TX_SCHED_WATCHDOG_EN
  always_ff @(posedge CLK or negedge RST)
    if (!RST) wd_err <= 1'b0;
    else wd_err <= wd_n;
`else
  assign wd_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed steps with a byte scoreboard and a simple busy-pulse UART model
module tb_uart_tx_sched;
  localparam int WDL = 8;
  logic CLK = 0, RST = 0;
  logic alu_req = 0, rf_req = 0;
  logic [15:0] alu_data = '0;
  logic [7:0] rf_data = '0;
  logic alu_ack, rf_ack, tx_data_valid, tx_busy, sched_busy, wd_err;
  logic [7:0] tx_p_data;
  int total = 0, bad = 0, strobes = 0, alu_acks = 0, cyc = 0, busy_cnt = 0;
  int n, sc0, ack0;
  bit uart_en = 1;
  logic [7:0] exp_q[$];
  int ack_log[$];
  int strobe_cyc[$];

  always #5 CLK = ~CLK;

  uart_tx_sched dut (
    .CLK(CLK), .RST(RST),
    .alu_req(alu_req), .alu_data(alu_data), .alu_ack(alu_ack),
    .rf_req(rf_req), .rf_data(rf_data), .rf_ack(rf_ack),
    .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid), .tx_busy(tx_busy),
    .sched_busy(sched_busy), .wd_err(wd_err)
  );

  // UART stand-in: busy rises the cycle after a strobe and stays high for three cycles
  assign tx_busy = busy_cnt != 0;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RST) busy_cnt <= 0;
    else if (tx_data_valid && uart_en) busy_cnt <= 3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (sched_busy && k < 100) begin
      tick(1);
      k++;
    end
    chk(tag, sched_busy, 0);
  endtask

  task automatic wait_acks(input string tag);
    int k = 0;
    while ((alu_req || rf_req) && k < 100) begin
      tick(1);
      if (alu_ack) alu_req = 0;
      if (rf_ack) rf_req = 0;
      k++;
    end
    chk(tag, {alu_req, rf_req}, 0);
  endtask

  always @(negedge CLK) if (RST) begin
    chk("valid_while_busy", tx_data_valid & tx_busy, 0);
    if (tx_data_valid) begin
      strobes++;
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_strobe", tx_p_data, 'x);
      else chk("byte", tx_p_data, exp_q.pop_front());
    end
    if (alu_ack) begin
      alu_acks++;
      ack_log.push_back(0);
    end
    if (rf_ack) ack_log.push_back(1);
  end

  initial begin
    #1;
    chk("reset_outs", {alu_ack, rf_ack, tx_data_valid, tx_p_data, sched_busy, wd_err}, 0);
    tick(2);
    RST = 1;
    tick(1);
    rf_data = 8'hA5;
    rf_req = 1;
    exp_q.push_back(8'hA5);
    tick(1);
    chk("rf_ack_c1", {rf_ack, alu_ack, tx_data_valid}, 3'b100);
    rf_req = 0;
    tick(1);
    chk("rf_strobe_c2", {rf_ack, tx_data_valid, tx_p_data}, {2'b01, 8'hA5});
    n = 0;
    while (sched_busy && n < 50) begin
      tick(1);
      n++;
    end
    chk("rf_idle_latency", n, 5);
    chk("rf_q_empty", exp_q.size(), 0);
    alu_data = 16'h1234;
    alu_req = 1;
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    sc0 = strobes;
    ack0 = alu_acks;
    tick(1);
    chk("alu_ack_c1", alu_ack, 1);
    alu_req = 0;
    tick(1);
    chk("alu_lo_strobe", {tx_data_valid, tx_p_data}, {1'b1, 8'h34});
    wait_idle("alu_idle");
    chk("alu_strobes", strobes - sc0, 2);
    chk("alu_acks", alu_acks - ack0, 1);
    chk("alu_gap", strobe_cyc[$] - strobe_cyc[$-1], 7);
    chk("alu_q_empty", exp_q.size(), 0);
    RST = 0;
    tick(1);
    RST = 1;
    tick(1);
    ack_log.delete();
    for (int r = 0; r < 2; r++) begin
      alu_data = 16'hBE00 | 16'(r);
      rf_data = 8'h5A + 8'(r);
      alu_req = 1;
      rf_req = 1;
      exp_q.push_back(8'(r));
      exp_q.push_back(8'hBE);
      exp_q.push_back(8'h5A + 8'(r));
      wait_acks($sformatf("acks_round%0d", r));
      wait_idle($sformatf("idle_round%0d", r));
    end
    chk("grant_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("grant%0d", i), ack_log.size() > i ? ack_log[i] : -1, i % 2);
    chk("order_q_empty", exp_q.size(), 0);
    alu_data = 16'h1234;
    alu_req = 1;
    exp_q.push_back(8'h34);
    sc0 = strobes;
    tick(1);
    alu_req = 0;
    tick(1);
    chk("pre_rst_strobe", {tx_data_valid, tx_p_data}, {1'b1, 8'h34});
    tick(2);
    chk("pre_rst_wait_lo", {sched_busy, tx_busy}, 2'b11);
    RST = 0;
    #1;
    chk("rst_async", {alu_ack, rf_ack, tx_data_valid, tx_p_data, sched_busy, wd_err}, 0);
    tick(1);
    RST = 1;
    tick(20);
    chk("no_resend", strobes - sc0, 1);
    chk("rst_q_empty", exp_q.size(), 0);
    chk("rst_idle", sched_busy, 0);
    uart_en = 0;
    rf_data = 8'h77;
    rf_req = 1;
    exp_q.push_back(8'h77);
    sc0 = strobes;
    tick(1);
    rf_req = 0;
    tick(1);
    chk("wd_strobe", {tx_data_valid, tx_p_data}, {1'b1, 8'h77});
`ifdef UART_TX_SCHED_WATCHDOG_EN
    n = 0;
    while (!wd_err && n < 50) begin
      tick(1);
      n++;
    end
    chk("wd_latency", n, WDL);
    chk("wd_idle", sched_busy, 0);
    tick(1);
    chk("wd_pulse_one", wd_err, 0);
    tick(20);
    chk("wd_no_second", strobes - sc0, 1);
`else
    tick(30);
    chk("wd_off_waits", {wd_err, sched_busy}, 2'b01);
    chk("wd_off_strobes", strobes - sc0, 1);
    RST = 0;
    tick(1);
    RST = 1;
`endif
    uart_en = 1;
    chk("final_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
